// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained by execute-stage
// resolution; raises a registered mispredict pulse with the redirect PC one cycle later.
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 30 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] FetchPC,
  output logic        PredTaken,
  output logic [31:0] PredTarget,
  input  logic        UpdValid,
  input  logic [31:0] UpdPC,
  input  logic        UpdIsBranch,
  input  logic        UpdIsJump,
  input  logic        UpdTaken,
  input  logic [31:0] UpdTarget,
  input  logic        UpdPredTaken,
  input  logic [31:0] UpdPredTarget,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredCount
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic                valid_q  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic [1:0]          ctr_q    [ENTRIES];
  logic                jump_q   [ENTRIES];

  logic                  mispred_q, mispred_d;
  logic [31:0]           redirect_q, redirect_d;
  logic [31:0]           bcount_q, bcount_d;
  logic [31:0]           mcount_q, mcount_d;

  logic [INDEX_BITS-1:0] f_idx, u_idx;
  logic [TAG_BITS-1:0]   f_tag, u_tag;
  logic                  f_hit, u_hit;
  logic                  upd_en, act_taken, wr_en;
  logic [1:0]            ctr_d;
  logic                  jump_d;
  logic [31:0]           target_d;
  logic                  unused_pc_bits;

  assign unused_pc_bits = ^{FetchPC[1:0], UpdPC[1:0]};

  assign f_idx      = FetchPC[INDEX_BITS+1:2];
  assign f_tag      = FetchPC[31:INDEX_BITS+2];
  assign f_hit      = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign PredTaken  = f_hit && (ctr_q[f_idx][1] || jump_q[f_idx]);
  assign PredTarget = f_hit ? target_q[f_idx] : FetchPC + 32'd4;

  assign u_idx     = UpdPC[INDEX_BITS+1:2];
  assign u_tag     = UpdPC[31:INDEX_BITS+2];
  assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_en    = UpdValid && (UpdIsBranch || UpdIsJump);
  // Jumps always redirect, whatever the branch unit reported as taken.
  assign act_taken = UpdIsJump || UpdTaken;

  always_comb begin
    wr_en    = 1'b0;
    ctr_d    = ctr_q[u_idx];
    jump_d   = jump_q[u_idx];
    target_d = target_q[u_idx];
    if (upd_en) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (UpdIsJump) begin
          ctr_d    = 2'b11;
          jump_d   = 1'b1;
          target_d = UpdTarget;
        end else if (UpdTaken) begin
          if (ctr_q[u_idx] != 2'b11) ctr_d = ctr_q[u_idx] + 2'b01;
          target_d = UpdTarget;
        end else begin
          if (ctr_q[u_idx] != 2'b00) ctr_d = ctr_q[u_idx] - 2'b01;
        end
      end else if (act_taken) begin
        wr_en    = 1'b1;
        ctr_d    = UpdIsJump ? 2'b11 : 2'b10;
        jump_d   = UpdIsJump;
        target_d = UpdTarget;
      end
    end
  end

  always_comb begin
    mispred_d  = upd_en && ((act_taken != UpdPredTaken) ||
                            (act_taken && (UpdTarget != UpdPredTarget)));
    redirect_d = redirect_q;
    if (mispred_d) redirect_d = act_taken ? UpdTarget : UpdPC + 32'd4;
    bcount_d = bcount_q;
    if (upd_en && (bcount_q != 32'hFFFF_FFFF)) bcount_d = bcount_q + 32'd1;
    mcount_d = mcount_q;
    if (mispred_d && (mcount_q != 32'hFFFF_FFFF)) mcount_d = mcount_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
        jump_q[i]   <= 1'b0;
      end
    end else if (wr_en) begin
      valid_q[u_idx]  <= 1'b1;
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= target_d;
      ctr_q[u_idx]    <= ctr_d;
      jump_q[u_idx]   <= jump_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_q  <= 1'b0;
      redirect_q <= '0;
      bcount_q   <= '0;
      mcount_q   <= '0;
    end else begin
      mispred_q  <= mispred_d;
      redirect_q <= redirect_d;
      bcount_q   <= bcount_d;
      mcount_q   <= mcount_d;
    end
  end

  assign Mispredict   = mispred_q;
  assign RedirectPC   = redirect_q;
  assign BranchCount  = bcount_q;
  assign MispredCount = mcount_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand-written corner sequences,
// then random traffic compared against a behavioural BTB model.
module tb_branch_predictor;

  logic        clk, rst_n;
  logic [31:0] FetchPC;
  logic        PredTaken;
  logic [31:0] PredTarget;
  logic        UpdValid, UpdIsBranch, UpdIsJump, UpdTaken, UpdPredTaken;
  logic [31:0] UpdPC, UpdTarget, UpdPredTarget;
  logic        Mispredict;
  logic [31:0] RedirectPC, BranchCount, MispredCount;

  int errors = 0;
  int checks = 0;

  branch_predictor dut (
    .clk(clk), .rst_n(rst_n), .FetchPC(FetchPC),
    .PredTaken(PredTaken), .PredTarget(PredTarget),
    .UpdValid(UpdValid), .UpdPC(UpdPC), .UpdIsBranch(UpdIsBranch),
    .UpdIsJump(UpdIsJump), .UpdTaken(UpdTaken), .UpdTarget(UpdTarget),
    .UpdPredTaken(UpdPredTaken), .UpdPredTarget(UpdPredTarget),
    .Mispredict(Mispredict), .RedirectPC(RedirectPC),
    .BranchCount(BranchCount), .MispredCount(MispredCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v, br, jp, tk, ptk;
    logic [31:0] pc, tgt, ptgt, fetch;
    logic        e_pt, e_mp;
    logic [31:0] e_ptgt, e_rd, e_bc, e_mc;
  } vec_t;

  function automatic vec_t mk(logic v, logic br, logic jp, logic tk, logic [31:0] pc,
                              logic [31:0] tgt, logic ptk, logic [31:0] ptgt,
                              logic [31:0] fetch, logic e_pt, logic [31:0] e_ptgt,
                              logic e_mp, logic [31:0] e_rd, logic [31:0] e_bc,
                              logic [31:0] e_mc);
    vec_t r;
    r.v = v; r.br = br; r.jp = jp; r.tk = tk; r.pc = pc; r.tgt = tgt;
    r.ptk = ptk; r.ptgt = ptgt; r.fetch = fetch; r.e_pt = e_pt; r.e_ptgt = e_ptgt;
    r.e_mp = e_mp; r.e_rd = e_rd; r.e_bc = e_bc; r.e_mc = e_mc;
    return r;
  endfunction

  task automatic drive(input logic v, input logic br, input logic jp, input logic tk,
                       input logic [31:0] pc, input logic [31:0] tgt, input logic ptk,
                       input logic [31:0] ptgt);
    UpdValid = v; UpdIsBranch = br; UpdIsJump = jp; UpdTaken = tk;
    UpdPC = pc; UpdTarget = tgt; UpdPredTaken = ptk; UpdPredTarget = ptgt;
  endtask

  // Behavioural model: slots keyed by index, tag compared as the whole word address.
  typedef struct { logic [31:0] word; logic [31:0] tgt; int ctr; bit jump; } ment_t;
  ment_t       mtab[int];
  logic        m_mp;
  logic [31:0] m_rd, m_bc, m_mc;

  function automatic int m_key(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    return mtab.exists(m_key(pc)) && (mtab[m_key(pc)].word == (pc >> 2));
  endfunction

  task automatic m_reset();
    mtab.delete();
    m_mp = 0; m_rd = 0; m_bc = 0; m_mc = 0;
  endtask

  task automatic m_predict(input logic [31:0] pc, output logic pt, output logic [31:0] tgt);
    if (m_hit(pc)) begin
      pt  = (mtab[m_key(pc)].ctr >= 2) || mtab[m_key(pc)].jump;
      tgt = mtab[m_key(pc)].tgt;
    end else begin
      pt  = 0;
      tgt = pc + 32'd4;
    end
  endtask

  task automatic m_update(input logic v, input logic br, input logic jp, input logic tk,
                          input logic [31:0] pc, input logic [31:0] tgt, input logic ptk,
                          input logic [31:0] ptgt);
    bit taken;
    ment_t e;
    m_mp = 0;
    if (!v || !(br || jp)) return;
    taken = jp || tk;
    if (m_bc != 32'hFFFF_FFFF) m_bc++;
    if ((taken != ptk) || (taken && tgt != ptgt)) begin
      m_mp = 1;
      if (m_mc != 32'hFFFF_FFFF) m_mc++;
      m_rd = taken ? tgt : pc + 32'd4;
    end
    if (m_hit(pc)) begin
      e = mtab[m_key(pc)];
      if (jp) begin e.ctr = 3; e.jump = 1; e.tgt = tgt; end
      else if (tk) begin e.ctr = (e.ctr + 1 > 3) ? 3 : e.ctr + 1; e.tgt = tgt; end
      else e.ctr = (e.ctr - 1 < 0) ? 0 : e.ctr - 1;
      mtab[m_key(pc)] = e;
    end else if (taken) begin
      e.word = pc >> 2; e.tgt = tgt; e.ctr = jp ? 3 : 2; e.jump = jp;
      mtab[m_key(pc)] = e;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    FetchPC = 32'h100;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  vec_t tbl[18];

  initial begin
    logic        e_pt;
    logic [31:0] e_tgt, fpc, pc, tgt, ptgt;
    logic        v, br, jp, tk, ptk;

    tbl[0]  = mk(0,0,0,0, 32'h0,   32'h0,   0, 32'h0,   32'h100, 0, 32'h104, 0, 32'h0,   0,  0);
    tbl[1]  = mk(1,1,0,1, 32'h100, 32'h80,  0, 32'h104, 32'h100, 1, 32'h80,  1, 32'h80,  1,  1);
    tbl[2]  = mk(1,1,0,0, 32'h100, 32'h80,  1, 32'h80,  32'h100, 0, 32'h80,  1, 32'h104, 2,  2);
    tbl[3]  = mk(1,1,0,0, 32'h100, 32'h80,  0, 32'h104, 32'h100, 0, 32'h80,  0, 32'h104, 3,  2);
    tbl[4]  = mk(1,1,0,1, 32'h100, 32'h80,  0, 32'h104, 32'h100, 0, 32'h80,  1, 32'h80,  4,  3);
    tbl[5]  = mk(1,1,0,1, 32'h100, 32'h80,  0, 32'h104, 32'h100, 1, 32'h80,  1, 32'h80,  5,  4);
    tbl[6]  = mk(1,1,0,1, 32'h100, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h80,  6,  4);
    tbl[7]  = mk(1,1,0,1, 32'h100, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h80,  7,  4);
    tbl[8]  = mk(1,1,0,1, 32'h100, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h80,  8,  4);
    tbl[9]  = mk(1,1,0,1, 32'h100, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  0, 32'h80,  9,  4);
    tbl[10] = mk(1,1,0,0, 32'h100, 32'h80,  1, 32'h80,  32'h100, 1, 32'h80,  1, 32'h104, 10, 5);
    tbl[11] = mk(1,0,1,1, 32'h200, 32'h400, 0, 32'h204, 32'h100, 0, 32'h104, 1, 32'h400, 11, 6);
    tbl[12] = mk(0,0,0,0, 32'h0,   32'h0,   0, 32'h0,   32'h200, 1, 32'h400, 0, 32'h400, 11, 6);
    tbl[13] = mk(1,1,0,0, 32'h300, 32'h600, 0, 32'h304, 32'h300, 0, 32'h304, 0, 32'h400, 12, 6);
    tbl[14] = mk(1,1,0,1, 32'h340, 32'h504, 1, 32'h500, 32'h340, 1, 32'h504, 1, 32'h504, 13, 7);
    tbl[15] = mk(1,0,1,0, 32'h400, 32'h800, 1, 32'h800, 32'h400, 1, 32'h800, 0, 32'h504, 14, 7);
    tbl[16] = mk(1,0,0,1, 32'h500, 32'h998, 0, 32'h504, 32'h500, 0, 32'h504, 0, 32'h504, 14, 7);
    tbl[17] = mk(0,0,0,0, 32'h0,   32'h0,   0, 32'h0,   32'hFFFF_FFFC, 0, 32'h0, 0, 32'h504, 14, 7);

    do_reset();
    chk("reset_pred_taken", PredTaken, 0);
    chk("reset_pred_target", PredTarget, 32'h104);
    chk("reset_mispredict", Mispredict, 0);
    chk("reset_redirect", RedirectPC, 0);
    chk("reset_branch_count", BranchCount, 0);
    chk("reset_mispred_count", MispredCount, 0);

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].v, tbl[i].br, tbl[i].jp, tbl[i].tk, tbl[i].pc, tbl[i].tgt,
            tbl[i].ptk, tbl[i].ptgt);
      FetchPC = tbl[i].fetch;
      @(posedge clk);
      #1 UpdValid = 1'b0;
      chk($sformatf("vec%0d_pred_taken", i), PredTaken, tbl[i].e_pt);
      chk($sformatf("vec%0d_pred_target", i), PredTarget, tbl[i].e_ptgt);
      chk($sformatf("vec%0d_mispredict", i), Mispredict, tbl[i].e_mp);
      chk($sformatf("vec%0d_redirect", i), RedirectPC, tbl[i].e_rd);
      chk($sformatf("vec%0d_branch_count", i), BranchCount, tbl[i].e_bc);
      chk($sformatf("vec%0d_mispred_count", i), MispredCount, tbl[i].e_mc);
    end

    // Lookup and update of the same PC in one cycle: old data now, new data after the edge.
    FetchPC = 32'h100;
    drive(1, 1, 0, 1, 32'h100, 32'h180, 0, 32'h104);
    #1;
    chk("war_pre_taken", PredTaken, 0);
    chk("war_pre_target", PredTarget, 32'h104);
    @(posedge clk);
    #1 UpdValid = 1'b0;
    chk("war_post_taken", PredTaken, 1);
    chk("war_post_target", PredTarget, 32'h180);
    chk("war_mispredict", Mispredict, 1);
    chk("war_redirect", RedirectPC, 32'h180);
    @(posedge clk);
    #1;
    chk("mispredict_clears", Mispredict, 0);

    // Reset asserted while an update is pending: that update must vanish.
    drive(1, 0, 1, 1, 32'h100, 32'h900, 0, 32'h104);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_taken", PredTaken, 0);
    chk("rst_async_target", PredTarget, 32'h104);
    chk("rst_async_bcount", BranchCount, 0);
    chk("rst_async_mcount", MispredCount, 0);
    chk("rst_async_mispredict", Mispredict, 0);
    @(posedge clk);
    #1 UpdValid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_discard_taken", PredTaken, 0);
    chk("rst_discard_target", PredTarget, 32'h104);
    chk("rst_discard_bcount", BranchCount, 0);
    chk("rst_discard_redirect", RedirectPC, 0);

    // Random traffic on a small PC pool so slots alias and hit frequently.
    do_reset();
    m_reset();
    for (int n = 0; n < 400; n++) begin
      fpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
            : ((32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2));
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC
            : ((32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2));
      v   = ($urandom_range(0, 3) != 0);
      br  = 1'($urandom_range(0, 1));
      jp  = ($urandom_range(0, 3) == 0);
      tk  = 1'($urandom_range(0, 1));
      ptk = 1'($urandom_range(0, 1));
      tgt = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
      case ($urandom_range(0, 2))
        0:       ptgt = tgt;
        1:       ptgt = pc + 32'd4;
        default: ptgt = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
      endcase
      FetchPC = fpc;
      drive(v, br, jp, tk, pc, tgt, ptk, ptgt);
      m_predict(fpc, e_pt, e_tgt);
      #1;
      chk($sformatf("rnd%0d_pred_taken", n), PredTaken, e_pt);
      chk($sformatf("rnd%0d_pred_target", n), PredTarget, e_tgt);
      @(posedge clk);
      #1 UpdValid = 1'b0;
      m_update(v, br, jp, tk, pc, tgt, ptk, ptgt);
      chk($sformatf("rnd%0d_mispredict", n), Mispredict, m_mp);
      chk($sformatf("rnd%0d_redirect", n), RedirectPC, m_rd);
      chk($sformatf("rnd%0d_branch_count", n), BranchCount, m_bc);
      chk($sformatf("rnd%0d_mispred_count", n), MispredCount, m_mc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
